// File: rtl/pipeline_ctrl.sv
// Pipeline sequencer: freeze/flush/bubble/hold control and branch redirect for the 5-stage pipe.
// Optional PIPE_CTRL_PERF_EN adds stall/branch/memwait performance counters.
module pipeline_ctrl #(
  parameter int WORD_WIDTH   = 32,
  parameter int FLUSH_CYCLES = 1,
  parameter int MEM_TIMEOUT  = 15,
  parameter int CNT_W        = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  hazard,
  input  logic                  branch_req,
  input  logic [WORD_WIDTH-1:0] branch_addr_in,
  input  logic                  mem_busy,
  output logic                  if_freeze,
  output logic                  if_flush,
  output logic                  id_bubble,
  output logic                  pipe_hold,
  output logic                  branch_taken,
  output logic [WORD_WIDTH-1:0] branch_addr,
`ifdef PIPE_CTRL_PERF_EN
  output logic [CNT_W-1:0]      perf_stall_cnt,
  output logic [CNT_W-1:0]      perf_flush_cnt,
  output logic [CNT_W-1:0]      perf_mem_cnt,
`endif
  output logic                  mem_timeout
);

  localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  typedef enum logic [1:0] {RUN, FLUSH, MEMWAIT} state_t;

  state_t        state, ret_state;
  logic [3:0]    wait_cnt;
  logic [FW-1:0] flush_cnt;
  logic          pend;
  logic          hold, accept, stall, flushing;

  // mem_busy holds the pipe in the same cycle it appears, ahead of branch and hazard
  always_comb begin
    hold     = mem_busy || (state == MEMWAIT);
    accept   = !hold && branch_req;
    stall    = !hold && !branch_req && hazard && (state == RUN);
    flushing = !hold && (branch_req || (state == FLUSH));
  end

  assign pipe_hold    = !rst && hold;
  assign if_freeze    = !rst && (hold || stall);
  assign if_flush     = !rst && flushing;
  assign id_bubble    = !rst && (flushing || stall);
  // redirect is deferred while held so IF sees it exactly once
  assign branch_taken = !rst && pend && !hold;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= RUN;
      ret_state   <= RUN;
      wait_cnt    <= '0;
      flush_cnt   <= '0;
      pend        <= 1'b0;
      branch_addr <= '0;
      mem_timeout <= 1'b0;
    end else begin
      if (accept) begin
        branch_addr <= branch_addr_in;
        pend        <= 1'b1;
      end else if (pend && !hold) begin
        pend <= 1'b0;
      end
      case (state)
        RUN: begin
          if (mem_busy) begin
            state     <= MEMWAIT;
            ret_state <= RUN;
            wait_cnt  <= 4'd1;
          end else if (branch_req && (FLUSH_CYCLES > 1)) begin
            state     <= FLUSH;
            flush_cnt <= FW'(FLUSH_CYCLES - 1);
          end
        end
        FLUSH: begin
          // flush_cnt is left untouched across the memory wait
          if (mem_busy) begin
            state     <= MEMWAIT;
            ret_state <= FLUSH;
            wait_cnt  <= 4'd1;
          end else if (branch_req) begin
            flush_cnt <= FW'(FLUSH_CYCLES - 1);
          end else if (flush_cnt <= FW'(1)) begin
            state     <= RUN;
            flush_cnt <= '0;
          end else begin
            flush_cnt <= flush_cnt - FW'(1);
          end
        end
        MEMWAIT: begin
          if (mem_busy) begin
            if (wait_cnt == 4'(MEM_TIMEOUT)) mem_timeout <= 1'b1;
            if (wait_cnt < 4'(MEM_TIMEOUT)) wait_cnt <= wait_cnt + 4'd1;
          end else begin
            state    <= ret_state;
            wait_cnt <= '0;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
      perf_mem_cnt   <= '0;
    end else begin
      if (stall)              perf_stall_cnt <= perf_stall_cnt + CNT_W'(1);
      if (accept)             perf_flush_cnt <= perf_flush_cnt + CNT_W'(1);
      if (state == MEMWAIT)   perf_mem_cnt   <= perf_mem_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl with FLUSH_CYCLES=2, MEM_TIMEOUT=15.
module tb_pipeline_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        hazard, branch_req, mem_busy;
  logic [31:0] branch_addr_in;
  logic        if_freeze, if_flush, id_bubble, pipe_hold, branch_taken, mem_timeout;
  logic [31:0] branch_addr;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] perf_stall_cnt, perf_flush_cnt, perf_mem_cnt;
`endif

  int total = 0;
  int bad   = 0;
  int nflush;

  pipeline_ctrl #(.WORD_WIDTH(32), .FLUSH_CYCLES(2), .MEM_TIMEOUT(15), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .hazard(hazard), .branch_req(branch_req),
    .branch_addr_in(branch_addr_in), .mem_busy(mem_busy),
    .if_freeze(if_freeze), .if_flush(if_flush), .id_bubble(id_bubble),
    .pipe_hold(pipe_hold), .branch_taken(branch_taken), .branch_addr(branch_addr),
`ifdef PIPE_CTRL_PERF_EN
    .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt), .perf_mem_cnt(perf_mem_cnt),
`endif
    .mem_timeout(mem_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  // frz, flush, bubble, hold, taken
  task automatic ctl(input string tag, input logic [4:0] exp);
    chk({tag, ".freeze"}, 32'(if_freeze),    32'(exp[4]));
    chk({tag, ".flush"},  32'(if_flush),     32'(exp[3]));
    chk({tag, ".bubble"}, 32'(id_bubble),    32'(exp[2]));
    chk({tag, ".hold"},   32'(pipe_hold),    32'(exp[1]));
    chk({tag, ".taken"},  32'(branch_taken), 32'(exp[0]));
  endtask

  // apply inputs just after the edge, leave time at mid-cycle for checks
  task automatic cyc(input logic h, input logic b, input logic [31:0] a, input logic m);
    @(posedge clk);
    #1;
    hazard = h; branch_req = b; branch_addr_in = a; mem_busy = m;
    #5;
  endtask

  initial begin
    rst = 1'b1; hazard = 0; branch_req = 0; branch_addr_in = '0; mem_busy = 0;
    #12;
    ctl("reset", 5'b00000);
    chk("reset.addr", branch_addr, 32'h0);
    chk("reset.tmo", 32'(mem_timeout), 32'h0);
    @(posedge clk); #1; rst = 1'b0;

    // hazard stall for two cycles
    cyc(1, 0, 0, 0); ctl("haz1", 5'b10100);
    cyc(1, 0, 0, 0); ctl("haz2", 5'b10100);
    cyc(0, 0, 0, 0); ctl("haz_end", 5'b00000);

    // branch to 0x40: two flush cycles, redirect in the second; hazard ignored in FLUSH
    cyc(0, 1, 32'h40, 0); ctl("br_acc", 5'b01100);
    cyc(1, 0, 0, 0);      ctl("br_fl2", 5'b01101);
    chk("br_addr", branch_addr, 32'h40);
    cyc(0, 0, 0, 0);      ctl("br_end", 5'b00000);
    chk("br_addr_hold", branch_addr, 32'h40);

    // all three requests at once: memory wait wins, no branch accepted
    cyc(1, 1, 32'h80, 1); ctl("all3", 5'b10010);
    cyc(0, 0, 0, 0);      ctl("all3_exit", 5'b10010);
    cyc(0, 0, 0, 0);      ctl("all3_run", 5'b00000);
    chk("all3_addr", branch_addr, 32'h40);

    // memory wait in the middle of a flush; redirect deferred past the wait
    nflush = 0;
    cyc(0, 1, 32'h100, 0); ctl("fw_acc", 5'b01100);  nflush += int'(if_flush);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 1); ctl("fw_busy", 5'b10010);     nflush += int'(if_flush);
    end
    cyc(0, 0, 0, 0); ctl("fw_exit", 5'b10010);       nflush += int'(if_flush);
    cyc(0, 0, 0, 0); ctl("fw_resume", 5'b01101);     nflush += int'(if_flush);
    chk("fw_addr", branch_addr, 32'h100);
    cyc(0, 0, 0, 0); ctl("fw_end", 5'b00000);        nflush += int'(if_flush);
    chk("fw_nflush", 32'(nflush), 32'd2);
    chk("fw_tmo", 32'(mem_timeout), 32'h0);

    // 15 busy cycles stays below the timeout
    for (int i = 0; i < 15; i++) cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 0); chk("tmo15", 32'(mem_timeout), 32'h0);
    cyc(0, 0, 0, 0);

    // 16 busy cycles trips it, and it sticks
    for (int i = 0; i < 16; i++) cyc(0, 0, 0, 1);
    chk("tmo16_last", 32'(mem_timeout), 32'h0);
    cyc(0, 0, 0, 0); chk("tmo16", 32'(mem_timeout), 32'h1);
    cyc(0, 0, 0, 0); chk("tmo_sticky", 32'(mem_timeout), 32'h1);
    ctl("tmo_run", 5'b00000);

    // reset asserted during a memory wait
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);
    rst = 1'b1; #1;
    ctl("rst_mw", 5'b00000);
    chk("rst_mw.tmo", 32'(mem_timeout), 32'h0);
    chk("rst_mw.addr", branch_addr, 32'h0);
    @(posedge clk); #1; rst = 1'b0; mem_busy = 0;
    cyc(0, 0, 0, 0); ctl("rst_after", 5'b00000);
    cyc(1, 0, 0, 0); ctl("rst_haz", 5'b10100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
